pr_timer: RTL and testbench

PR_TIMER -- requirements
Module: pr_timer

---
 rtl/pr_timer.sv | 106 ++++++++++
 tb/tb_pr_timer.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pr_timer.sv
// Memory-mapped down-counting timer with CTRL/PRESET/COUNT registers and a maskable interrupt.
// Optional macro PR_TIMER_AUTORELOAD_EN enables Mode=1 auto-reload; otherwise every mode is one-shot.
module pr_timer (
  input  logic        clk,
  input  logic        reset,
  input  logic        sel,
  input  logic [1:0]  addr,
  input  logic        we,
  input  logic [31:0] wd,
  output logic [31:0] rd,
  output logic        irq
);

  typedef enum logic [1:0] {StIdle, StLoad, StCnt, StInt} state_e;

  state_e      state_q;
  logic [3:0]  ctrl_q;
  logic [31:0] preset_q;
  logic [31:0] count_q;
  logic        irq_pend_q;

  logic en;
  logic im;
  logic auto_reload;
  logic ctrl_wr;
  logic preset_wr;

  assign en        = ctrl_q[0];
  assign im        = ctrl_q[3];
  assign ctrl_wr   = sel & we & (addr == 2'd0);
  assign preset_wr = sel & we & (addr == 2'd1);

`ifdef PR_TIMER_AUTORELOAD_EN
  assign auto_reload = (ctrl_q[2:1] == 2'b01);
`else
  assign auto_reload = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      ctrl_q     <= 4'd0;
      preset_q   <= 32'd0;
      count_q    <= 32'd0;
      irq_pend_q <= 1'b0;
    end else begin
      if (preset_wr) begin
        preset_q <= wd;
      end

      case (state_q)
        StIdle: begin
          if (en) begin
            state_q <= StLoad;
          end
        end
        StLoad: begin
          count_q <= preset_q;
          state_q <= StCnt;
          // Ends the single-cycle pulse raised by the previous auto-reload expiry.
          if (auto_reload) begin
            irq_pend_q <= 1'b0;
          end
        end
        StCnt: begin
          if (!en) begin
            state_q <= StIdle;
          end else if (count_q > 32'd1) begin
            count_q <= count_q - 32'd1;
          end else begin
            count_q <= 32'd0;
            state_q <= StInt;
          end
        end
        StInt: begin
          irq_pend_q <= 1'b1;
          if (auto_reload && en) begin
            state_q <= StLoad;
          end else begin
            ctrl_q[0] <= 1'b0;
            state_q   <= StIdle;
          end
        end
      endcase

      // Software CTRL writes take priority over the FSM's En and irq_pend updates.
      if (ctrl_wr) begin
        ctrl_q     <= wd[3:0];
        irq_pend_q <= 1'b0;
      end
    end
  end

  always_comb begin
    rd = 32'd0;
    case (addr)
      2'd0:    rd = {28'd0, ctrl_q};
      2'd1:    rd = preset_q;
      2'd2:    rd = count_q;
      default: rd = 32'd0;
    endcase
  end

  assign irq = irq_pend_q & im;

endmodule

// File: tb/tb_pr_timer.sv
// Scoreboard bench for pr_timer: stimulus queues expected values, a negedge monitor compares them.
// Handles both builds; the Mode=1 checks follow PR_TIMER_AUTORELOAD_EN.
module tb_pr_timer;

  logic        clk = 1'b0;
  logic        reset;
  logic        sel;
  logic [1:0]  addr;
  logic        we;
  logic [31:0] wd;
  logic [31:0] rd;
  logic        irq;

  typedef struct {
    bit          is_irq;
    logic [31:0] exp;
    string       name;
  } exp_t;

  exp_t sb[$];
  logic mon_v = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;

  pr_timer u_dut (
    .clk  (clk),
    .reset(reset),
    .sel  (sel),
    .addr (addr),
    .we   (we),
    .wd   (wd),
    .rd   (rd),
    .irq  (irq)
  );

  always #5 clk = ~clk;

  // Monitor: pops one expectation per flagged cycle and compares away from the rising edge.
  always @(negedge clk) begin
    if (mon_v) begin
      if (sb.size() == 0) begin
        miscompares++;
        $display("FAIL scoreboard_empty: got no expectation, required one");
      end else begin
        exp_t        it;
        logic [31:0] act;
        it  = sb.pop_front();
        act = it.is_irq ? {31'd0, irq} : rd;
        vectors++;
        if (act !== it.exp) begin
          miscompares++;
          $display("FAIL %s: got 0x%08h, required 0x%08h", it.name, act, it.exp);
        end
      end
    end
  end

  initial begin
    #2000000;
    miscompares++;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog expired");
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic bus_wr(input logic [1:0] a, input logic [31:0] d);
    sel  = 1'b1;
    we   = 1'b1;
    addr = a;
    wd   = d;
    @(posedge clk);
    #1;
    sel = 1'b0;
    we  = 1'b0;
  endtask

  // Each check samples the current cycle and returns just after the next rising edge.
  task automatic chk(input bit is_irq, input logic [1:0] a, input logic [31:0] e,
                     input string nm);
    exp_t it;
    addr      = a;
    it.is_irq = is_irq;
    it.exp    = e;
    it.name   = nm;
    sb.push_back(it);
    mon_v = 1'b1;
    @(negedge clk);
    #1;
    mon_v = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_rd(input logic [1:0] a, input logic [31:0] e, input string nm);
    chk(1'b0, a, e, nm);
  endtask

  task automatic chk_irq(input logic e, input string nm);
    chk(1'b1, addr, {31'd0, e}, nm);
  endtask

  initial begin
    reset = 1'b1;
    sel   = 1'b0;
    we    = 1'b0;
    addr  = 2'd0;
    wd    = 32'd0;
    step(3);
    reset = 1'b0;

    chk_rd(2'd0, 32'd0, "rst_ctrl");
    chk_rd(2'd1, 32'd0, "rst_preset");
    chk_rd(2'd2, 32'd0, "rst_count");
    chk_rd(2'd3, 32'd0, "rst_rsvd");
    chk_irq(1'b0, "rst_irq");

    // Register access: PRESET readback, COUNT/reserved read-only, CTRL keeps bits 3:0.
    bus_wr(2'd1, 32'hA5A5_0005);
    chk_rd(2'd1, 32'hA5A5_0005, "preset_rb");
    bus_wr(2'd2, 32'hDEAD_BEEF);
    bus_wr(2'd3, 32'h1234_5678);
    chk_rd(2'd2, 32'd0, "count_ro");
    chk_rd(2'd3, 32'd0, "rsvd_ro");
    bus_wr(2'd0, 32'hFFFF_FFF6);
    chk_rd(2'd0, 32'd6, "ctrl_rb");
    chk_irq(1'b0, "ctrl_rb_irq");
    bus_wr(2'd0, 32'd0);

    // Mode 0 one-shot, PRESET=5, CTRL written at edge t.
    bus_wr(2'd1, 32'd5);
    bus_wr(2'd0, 32'h9);
    step(2);
    chk_rd(2'd2, 32'd5, "m0_load");       // t+2
    step(3);
    chk_irq(1'b0, "m0_irq_early");        // t+6
    chk_rd(2'd2, 32'd0, "m0_count0");     // t+7
    chk_irq(1'b1, "m0_irq_rise");         // t+8
    chk_rd(2'd0, 32'h8, "m0_en_clr");     // t+9
    chk_irq(1'b1, "m0_irq_hold");         // t+10

    // Clearing CTRL drops irq and the timer stays idle.
    bus_wr(2'd0, 32'd0);
    chk_irq(1'b0, "clr_irq");
    step(2);
    chk_rd(2'd2, 32'd0, "clr_idle_count");
    chk_rd(2'd0, 32'd0, "clr_ctrl");

    // CTRL write landing on the expiry edge keeps En and clears the pending interrupt.
    bus_wr(2'd0, 32'h9);
    step(7);
    bus_wr(2'd0, 32'h9);                  // edge t+8
    chk_rd(2'd0, 32'h9, "race_ctrl");
    chk_irq(1'b0, "race_irq");
    bus_wr(2'd0, 32'd0);
    step(3);

    // Zero preset with IM=0, then a masked-on write that clears irq_pend.
    bus_wr(2'd1, 32'd0);
    bus_wr(2'd0, 32'h1);
    step(3);
    chk_rd(2'd0, 32'h1, "zp_en_run");     // t+3
    chk_rd(2'd0, 32'h0, "zp_en_clr");     // t+4
    chk_irq(1'b0, "zp_masked");
    bus_wr(2'd0, 32'h8);
    chk_irq(1'b0, "zp_unmask_clr");
    step(3);
    chk_irq(1'b0, "zp_unmask_hold");

    // Mode 1, PRESET=3: first pulse 6 cycles after the CTRL write.
    bus_wr(2'd1, 32'd3);
    bus_wr(2'd0, 32'hB);
    step(5);
    chk_irq(1'b0, "m1_pre");              // t+5
    chk_irq(1'b1, "m1_pulse1");           // t+6
`ifdef PR_TIMER_AUTORELOAD_EN
    chk_rd(2'd2, 32'd3, "m1_reload");     // t+7
    chk_irq(1'b0, "m1_gap_a");
    chk_irq(1'b0, "m1_gap_b");
    chk_irq(1'b0, "m1_gap_c");
    chk_irq(1'b1, "m1_pulse2");           // t+11, PRESET+2 cycles after the first
    chk_irq(1'b0, "m1_pulse2_end");
    bus_wr(2'd0, 32'd0);
    step(3);
`else
    chk_rd(2'd0, 32'hA, "m1_as_oneshot"); // mode bits kept, En cleared
    chk_irq(1'b1, "m1_hold_a");
    step(2);
    chk_irq(1'b1, "m1_hold_b");
    bus_wr(2'd0, 32'd0);
    chk_irq(1'b0, "m1_clr");
`endif

    // Pause mid-count, then restart reloads from PRESET.
    bus_wr(2'd1, 32'd100);
    bus_wr(2'd0, 32'h9);
    step(11);
    chk_rd(2'd2, 32'd91, "pause_run");    // t+11
    bus_wr(2'd0, 32'h8);                  // edge t+13, COUNT was 90
    step(10);
    chk_rd(2'd2, 32'd89, "pause_hold");
    chk_irq(1'b0, "pause_irq");
    bus_wr(2'd0, 32'h9);
    step(2);
    chk_rd(2'd2, 32'd100, "pause_reload");
    bus_wr(2'd0, 32'd0);
    step(2);

    // Reset mid-count overrides a simultaneous PRESET write.
    bus_wr(2'd1, 32'd50);
    bus_wr(2'd0, 32'h9);
    step(32);
    chk_rd(2'd2, 32'd20, "mid_count");
    reset = 1'b1;
    sel   = 1'b1;
    we    = 1'b1;
    addr  = 2'd1;
    wd    = 32'h0000_1234;
    @(posedge clk);
    #1;
    reset = 1'b0;
    sel   = 1'b0;
    we    = 1'b0;
    chk_rd(2'd0, 32'd0, "mrst_ctrl");
    chk_rd(2'd1, 32'd0, "mrst_preset");
    chk_rd(2'd2, 32'd0, "mrst_count");
    chk_rd(2'd3, 32'd0, "mrst_rsvd");
    for (int i = 0; i < 100; i++) begin
      chk_irq(1'b0, "mrst_no_irq");
    end
    chk_rd(2'd2, 32'd0, "mrst_count_end");

    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain: got %0d left, required 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
